// File: rtl/color_index_encoder.sv
// color_index_encoder
//   Maps a 24-bit RGB pixel to the index of the nearest palette colour.
//   Nearest means smallest Manhattan distance |dR|+|dG|+|dB|.
//   The search checks one palette entry per clock:
//     RED, GREEN, BLUE, WHITE, BLACK (k = 0..4).
//   Ties go to the lowest k.
//   The palette indices use the 8-bit RGB332 VRAM colour byte encoding.
//   Optional feature macro: COLOR_ENC_CACHE_EN.
//     When defined, a 1-entry result cache lets a repeat of the last
//     searched pixel skip the search.
//
// Handshakes (both sides): a transfer occurs on a rising edge where valid
//   and ready are both 1. A producer holds valid and its payload steady
//   until that edge. out_index/out_dist/out_exact are stable while
//   out_valid=1. in_ready is high only in IDLE, so a new pixel is never
//   accepted on the same edge that a result is handed off.
module color_index_encoder #(
    parameter int NUM_COLORS = 5,
    parameter int IDX_W      = 8,
    parameter int DIST_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [23:0]       in_rgb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic [DIST_W-1:0] out_dist,
    output logic              out_exact,
    output logic [1:0]        dbg_state
);

    localparam logic [IDX_W-1:0] IDX_RED   = IDX_W'(8'hE0);
    localparam logic [IDX_W-1:0] IDX_GREEN = IDX_W'(8'h1C);
    localparam logic [IDX_W-1:0] IDX_BLUE  = IDX_W'(8'h03);
    localparam logic [IDX_W-1:0] IDX_WHITE = IDX_W'(8'hFF);
    localparam logic [IDX_W-1:0] IDX_BLACK = IDX_W'(8'h00);
    localparam logic [2:0]       K_LAST    = 3'(NUM_COLORS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [2:0]         k;
    logic [23:0]        rgb_q;
    logic [DIST_W-1:0]  best_dist;
    logic [IDX_W-1:0]   best_idx;

    logic               accept;
    logic               handoff;
    logic               cache_hit;
    logic [23:0]        pal_rgb;
    logic [IDX_W-1:0]   pal_idx;
    logic [7:0]         dr, dg, db;
    logic [DIST_W-1:0]  d;
    logic               better;
    logic [DIST_W-1:0]  fin_dist;
    logic [IDX_W-1:0]   fin_idx;

`ifdef COLOR_ENC_CACHE_EN
    logic               cache_vld;
    logic [23:0]        cache_rgb;
    logic [IDX_W-1:0]   cache_idx;
    logic [DIST_W-1:0]  cache_dist;
`endif

    assign accept  = in_valid && (state == IDLE);
    assign handoff = out_ready && (state == DONE);

`ifdef COLOR_ENC_CACHE_EN
    assign cache_hit = cache_vld && (in_rgb == cache_rgb);
`else
    assign cache_hit = 1'b0;
`endif

    // Palette entry k: colour value and its VRAM index
    always_comb begin
        pal_rgb = 24'h000000;
        pal_idx = IDX_BLACK;
        case (k)
            3'd0:    begin pal_rgb = 24'hFF0000; pal_idx = IDX_RED;   end
            3'd1:    begin pal_rgb = 24'h00FF00; pal_idx = IDX_GREEN; end
            3'd2:    begin pal_rgb = 24'h0000FF; pal_idx = IDX_BLUE;  end
            3'd3:    begin pal_rgb = 24'hFFFFFF; pal_idx = IDX_WHITE; end
            default: begin pal_rgb = 24'h000000; pal_idx = IDX_BLACK; end
        endcase
    end

    // Manhattan distance of the latched pixel to entry k; strict-less compare keeps the lowest k on ties
    always_comb begin
        dr = (rgb_q[23:16] > pal_rgb[23:16]) ? rgb_q[23:16] - pal_rgb[23:16]
                                             : pal_rgb[23:16] - rgb_q[23:16];
        dg = (rgb_q[15:8] > pal_rgb[15:8]) ? rgb_q[15:8] - pal_rgb[15:8]
                                           : pal_rgb[15:8] - rgb_q[15:8];
        db = (rgb_q[7:0] > pal_rgb[7:0]) ? rgb_q[7:0] - pal_rgb[7:0]
                                         : pal_rgb[7:0] - rgb_q[7:0];
        d        = DIST_W'(dr) + DIST_W'(dg) + DIST_W'(db);
        better   = (d < best_dist);
        fin_dist = better ? d : best_dist;
        fin_idx  = better ? pal_idx : best_idx;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = cache_hit ? DONE : SEARCH;
            SEARCH:  if (k == K_LAST)   state_nxt = DONE;
            DONE:    if (handoff)       state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        dbg_state = state;
    end

    // Search datapath: latch pixel, step through the palette, publish the result
    always_ff @(posedge clk) begin
        if (rst) begin
            k         <= 3'd0;
            rgb_q     <= 24'h000000;
            best_dist <= '1;
            best_idx  <= IDX_BLACK;
            out_index <= IDX_BLACK;
            out_dist  <= '0;
            out_exact <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rgb_q     <= in_rgb;
                        best_dist <= '1;
                        k         <= 3'd0;
`ifdef COLOR_ENC_CACHE_EN
                        if (cache_hit) begin
                            out_index <= cache_idx;
                            out_dist  <= cache_dist;
                            out_exact <= (cache_dist == '0);
                        end
`endif
                    end
                end
                SEARCH: begin
                    best_dist <= fin_dist;
                    best_idx  <= fin_idx;
                    if (k == K_LAST) begin
                        k         <= 3'd0;
                        out_index <= fin_idx;
                        out_dist  <= fin_dist;
                        out_exact <= (fin_dist == '0);
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef COLOR_ENC_CACHE_EN
    // Remember the last searched pixel and its result
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_vld  <= 1'b0;
            cache_rgb  <= 24'h000000;
            cache_idx  <= IDX_BLACK;
            cache_dist <= '0;
        end else if (state == SEARCH && k == K_LAST) begin
            cache_vld  <= 1'b1;
            cache_rgb  <= rgb_q;
            cache_idx  <= fin_idx;
            cache_dist <= fin_dist;
        end
    end
`endif

endmodule

// File: tb/tb_color_index_encoder.sv
// tb_color_index_encoder
//   Directed vectors for color_index_encoder with hand-computed results.
//   Covered: reset values, exact match, tie breaking, equidistant greys,
//   backpressure hold, reset during the search, and the repeat-pixel latency.
module tb_color_index_encoder;

    localparam logic [7:0] IDX_RED   = 8'hE0;
    localparam logic [7:0] IDX_GREEN = 8'h1C;
    localparam logic [7:0] IDX_WHITE = 8'hFF;
    localparam logic [7:0] IDX_BLACK = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_rgb;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_index;
    logic [9:0]  out_dist;
    logic        out_exact;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    color_index_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rgb    (in_rgb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_dist  (out_dist),
        .out_exact (out_exact),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a pixel and wait for the accepting edge; in_rgb is scrambled afterwards
    task automatic send(input logic [23:0] rgb);
        in_rgb   = rgb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_rgb   = ~rgb;
    endtask

    // Count edges after acceptance until out_valid, bounded
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic run_pixel(input string tag, input logic [23:0] rgb, input logic [7:0] e_idx,
                             input logic [9:0] e_dist, input logic e_exact, input int e_lat);
        int lat;
        send(rgb);
        wait_result(lat);
        check({tag, ".lat"}, lat, e_lat);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".idx"}, out_index, e_idx);
        check({tag, ".dist"}, out_dist, e_dist);
        check({tag, ".exact"}, out_exact, e_exact);
        step();
        check({tag, ".ovalid_after"}, out_valid, 1'b0);
        check({tag, ".iready_after"}, in_ready, 1'b1);
    endtask

    initial begin
        int lat;
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_rgb    = 24'h0;
        out_ready = 1'b1;
        step();
        step();
        check("rst.in_ready", in_ready, 1'b1);
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.out_index", out_index, IDX_BLACK);
        check("rst.out_dist", out_dist, 10'd0);
        check("rst.out_exact", out_exact, 1'b0);
        check("rst.state", dbg_state, 2'd0);
        rst = 1'b0;
        step();

        run_pixel("red",   24'hFF0000, IDX_RED,   10'd0,   1'b1, 5);
        run_pixel("tie",   24'hFF00FF, IDX_RED,   10'd255, 1'b0, 5);
        run_pixel("g80",   24'h808080, IDX_WHITE, 10'd381, 1'b0, 5);
        run_pixel("g7f",   24'h7F7F7F, IDX_BLACK, 10'd381, 1'b0, 5);
        run_pixel("white", 24'hFFFFFF, IDX_WHITE, 10'd0,   1'b1, 5);
        run_pixel("near",  24'h0A0B0C, IDX_BLACK, 10'd33,  1'b0, 5);

        // Backpressure: result and in_ready must hold for 10 cycles
        out_ready = 1'b0;
        send(24'h00F000);
        wait_result(lat);
        check("bp.lat", lat, 5);
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp.valid", out_valid, 1'b1);
            check("bp.idx", out_index, IDX_GREEN);
            check("bp.dist", out_dist, 10'd15);
            check("bp.in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        step();
        check("bp.release_valid", out_valid, 1'b0);
        check("bp.release_ready", in_ready, 1'b1);

        // Reset on the 3rd search cycle drops the pixel
        send(24'h0000FF);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid.in_ready", in_ready, 1'b1);
        check("rstmid.out_valid", out_valid, 1'b0);
        check("rstmid.out_index", out_index, IDX_BLACK);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen++;
        end
        check("rstmid.no_result", seen, 0);

        // Repeated pixel: cached build hands the result over right after the accepting edge
        run_pixel("rep1", 24'h00FE00, IDX_GREEN, 10'd1, 1'b0, 5);
`ifdef COLOR_ENC_CACHE_EN
        run_pixel("rep2", 24'h00FE00, IDX_GREEN, 10'd1, 1'b0, 0);
`else
        run_pixel("rep2", 24'h00FE00, IDX_GREEN, 10'd1, 1'b0, 5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
